// File: rtl/tdc_pkg.sv
// Shared definitions for the program loader and the core's decoder.
//   - 3-bit opcode values for the eight Brainfuck commands
//   - loader FSM state encoding
//   - loader error codes reported on err_code
package tdc_pkg;

  localparam logic [2:0] OP_INC   = 3'd0;  // +
  localparam logic [2:0] OP_DEC   = 3'd1;  // -
  localparam logic [2:0] OP_RIGHT = 3'd2;  // >
  localparam logic [2:0] OP_LEFT  = 3'd3;  // <
  localparam logic [2:0] OP_JZ    = 3'd4;  // [
  localparam logic [2:0] OP_JNZ   = 3'd5;  // ]
  localparam logic [2:0] OP_CIN   = 3'd6;  // ,
  localparam logic [2:0] OP_COUT  = 3'd7;  // .

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_DONE  = 2'd2,
    LD_ERROR = 2'd3
  } ld_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;  // ] with nothing open
  localparam logic [1:0] ERR_UNCLOSED  = 2'd2;  // terminator with [ still open
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;  // program too long or nested too deep

endpackage

// File: rtl/bf_char_encoder.sv
// Combinational classifier for one source byte.
// Ports:
//   i_data     ASCII source byte
//   o_is_cmd   byte is one of the eight command characters
//   o_is_open  byte is '['
//   o_is_close byte is ']'
//   o_is_end   byte is the 0x00 terminator
//   o_opcode   encoded opcode (0 when not a command)
module bf_char_encoder
  import tdc_pkg::*;
(
  input  logic [7:0] i_data,
  output logic       o_is_cmd,
  output logic       o_is_open,
  output logic       o_is_close,
  output logic       o_is_end,
  output logic [2:0] o_opcode
);

  always_comb begin
    o_is_cmd   = 1'b1;
    o_is_open  = 1'b0;
    o_is_close = 1'b0;
    o_is_end   = 1'b0;
    o_opcode   = OP_INC;
    case (i_data)
      8'h2B: o_opcode = OP_INC;    // +
      8'h2D: o_opcode = OP_DEC;    // -
      8'h3E: o_opcode = OP_RIGHT;  // >
      8'h3C: o_opcode = OP_LEFT;   // <
      8'h5B: begin                 // [
        o_opcode  = OP_JZ;
        o_is_open = 1'b1;
      end
      8'h5D: begin                 // ]
        o_opcode   = OP_JNZ;
        o_is_close = 1'b1;
      end
      8'h2C: o_opcode = OP_CIN;    // ,
      8'h2E: o_opcode = OP_COUT;   // .
      8'h00: begin
        o_is_cmd = 1'b0;
        o_is_end = 1'b1;
      end
      default: o_is_cmd = 1'b0;    // comment byte
    endcase
  end

endmodule

// File: rtl/pmem_loader.sv
// Loads Brainfuck source text into the core's 3-bit program memory.
// Command characters are encoded and written from address 0 upward,
// bracket balance and program length are checked, and the core is kept
// in reset until a complete, valid program has been written.
// Ports:
//   clock, reset_n    clock (rising edge) and asynchronous active-low reset
//   start             one-cycle pulse that begins a load
//   in_valid/in_data  source byte stream; 0x00 terminates the program
//   in_ready          byte is accepted when in_valid && in_ready
//   pmem_we/addr/data program memory write port, one strobe per opcode
//   core_hold         keeps the core in reset (low only after a good load)
//   done / error      load result levels; err_code gives the reason
//   prog_len          number of opcodes written so far
module pmem_loader
  import tdc_pkg::*;
#(
  parameter int PMEM_DEPTH = 65536,
  parameter int MAX_NEST   = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        pmem_we,
  output logic [15:0] pmem_addr,
  output logic [2:0]  pmem_data_write,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [16:0] prog_len
);

  localparam logic [16:0] LEN_MAX  = 17'(PMEM_DEPTH);
  localparam logic [7:0]  NEST_MAX = 8'(MAX_NEST);

  ld_state_e   r_state;
  logic [16:0] r_len;
  logic [7:0]  r_depth;
  logic        r_ready;
  logic        r_we;
  logic [15:0] r_addr;
  logic [2:0]  r_data;
  logic        r_hold;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;

  logic        w_is_cmd;
  logic        w_is_open;
  logic        w_is_close;
  logic        w_is_end;
  logic [2:0]  w_opcode;
  logic        w_accept;

  bf_char_encoder u_enc (
    .i_data     (in_data),
    .o_is_cmd   (w_is_cmd),
    .o_is_open  (w_is_open),
    .o_is_close (w_is_close),
    .o_is_end   (w_is_end),
    .o_opcode   (w_opcode)
  );

  assign w_accept = in_valid && r_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LD_IDLE;
      r_len      <= '0;
      r_depth    <= '0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          // in_ready is still low this cycle, so a byte offered alongside
          // start is not taken; the first byte lands on the next edge.
          if (start) begin
            r_state    <= LD_LOAD;
            r_len      <= '0;
            r_depth    <= '0;
            r_err_code <= ERR_NONE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (w_accept) begin
            if (w_is_end) begin
              r_ready <= 1'b0;
              if (r_depth == 8'd0) begin
                r_state <= LD_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else begin
                r_state    <= LD_ERROR;
                r_error    <= 1'b1;
                r_err_code <= ERR_UNCLOSED;
              end
            end else if (w_is_cmd) begin
              // Length is checked first so the address can never wrap.
              if ((r_len == LEN_MAX) || (w_is_open && (r_depth == NEST_MAX))) begin
                r_state    <= LD_ERROR;
                r_ready    <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= ERR_OVERFLOW;
              end else if (w_is_close && (r_depth == 8'd0)) begin
                r_state    <= LD_ERROR;
                r_ready    <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= ERR_UNMATCHED;
              end else begin
                r_we    <= 1'b1;
                r_addr  <= r_len[15:0];
                r_data  <= w_opcode;
                r_len   <= r_len + 17'd1;
                if (w_is_open)  r_depth <= r_depth + 8'd1;
                if (w_is_close) r_depth <= r_depth - 8'd1;
              end
            end
          end
        end
        default: r_state <= LD_IDLE;
      endcase
    end
  end

  assign in_ready        = r_ready;
  assign pmem_we         = r_we;
  assign pmem_addr       = r_addr;
  assign pmem_data_write = r_data;
  assign core_hold       = r_hold;
  assign done            = r_done;
  assign error           = r_error;
  assign err_code        = r_err_code;
  assign prog_len        = r_len;

endmodule
